pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-as-bubble and a flush-immune sideband.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid register (registered in_ready_o, full throughput).
module pipe_stage_reg #(
   parameter int unsigned      DATA_W     = 32,
   parameter int unsigned      CTRL_W     = 16,
   parameter int unsigned      SB_W       = 2,
   parameter logic [SB_W-1:0]  SB_RST     = '0,
   parameter bit               CLEAR_DATA = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   input  logic [SB_W-1:0]   sb_i,
   output logic [SB_W-1:0]   sb_o
);

   logic              out_valid_q, out_valid_d;
   logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [SB_W-1:0]   sb_q,        sb_d;
   logic              in_xfer;
   logic              main_free;

   assign in_xfer   = in_valid_i & in_ready_o;
   assign main_free = ~out_valid_q | out_ready_i;
   assign sb_d      = sb_i;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_valid_q, skid_valid_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic              in_ready_q,   in_ready_d;

   assign in_ready_o = in_ready_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_ctrl_d   = out_ctrl_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_data_d  = skid_data_q;
      if (flush_i) begin
         out_valid_d  = 1'b0;
         out_ctrl_d   = '0;
         out_data_d   = CLEAR_DATA ? '0 : out_data_q;
         skid_valid_d = 1'b0;
         skid_ctrl_d  = '0;
         skid_data_d  = CLEAR_DATA ? '0 : skid_data_q;
      end else if (main_free) begin
         if (skid_valid_q) begin
            // Skid drains first to keep acceptance order; a new beat refills the skid slot.
            out_valid_d = 1'b1;
            out_ctrl_d  = skid_ctrl_q;
            out_data_d  = skid_data_q;
            if (in_xfer) begin
               skid_ctrl_d = in_ctrl_i;
               skid_data_d = in_data_i;
            end else begin
               skid_valid_d = 1'b0;
               skid_ctrl_d  = '0;
            end
         end else if (in_xfer) begin
            out_valid_d = 1'b1;
            out_ctrl_d  = in_ctrl_i;
            out_data_d  = in_data_i;
         end else begin
            out_valid_d = 1'b0;
            out_ctrl_d  = '0;
         end
      end else if (in_xfer) begin
         skid_valid_d = 1'b1;
         skid_ctrl_d  = in_ctrl_i;
         skid_data_d  = in_data_i;
      end
      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         skid_valid_q <= 1'b0;
         skid_ctrl_q  <= '0;
         skid_data_q  <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= in_ready_d;
      end
   end
`else
   assign in_ready_o = main_free;

   always_comb begin
      out_valid_d = out_valid_q;
      out_ctrl_d  = out_ctrl_q;
      out_data_d  = out_data_q;
      if (flush_i) begin
         out_valid_d = 1'b0;
         out_ctrl_d  = '0;
         out_data_d  = CLEAR_DATA ? '0 : out_data_q;
      end else if (in_xfer) begin
         out_valid_d = 1'b1;
         out_ctrl_d  = in_ctrl_i;
         out_data_d  = in_data_i;
      end else if (main_free) begin
         out_valid_d = 1'b0;
         out_ctrl_d  = '0;
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         out_valid_q <= 1'b0;
         out_ctrl_q  <= '0;
         out_data_q  <= '0;
         sb_q        <= SB_RST;
      end else begin
         out_valid_q <= out_valid_d;
         out_ctrl_q  <= out_ctrl_d;
         out_data_q  <= out_data_d;
         sb_q        <= sb_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_ctrl_o  = out_ctrl_q;
   assign out_data_o  = out_data_q;
   assign sb_o        = sb_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + random bench for pipe_stage_reg: a queue of accepted beats is checked against emitted beats.
// Skid-specific expectations follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CTRL_W = 16;
   localparam int unsigned SB_W   = 2;
   localparam logic [1:0]  SB_RST = 2'b00;
`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              flush_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [CTRL_W-1:0] in_ctrl_i;
   logic [DATA_W-1:0] in_data_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [CTRL_W-1:0] out_ctrl_o;
   logic [DATA_W-1:0] out_data_o;
   logic [SB_W-1:0]   sb_i;
   logic [SB_W-1:0]   sb_o;

   pipe_stage_reg #(
      .DATA_W(DATA_W), .CTRL_W(CTRL_W), .SB_W(SB_W), .SB_RST(SB_RST), .CLEAR_DATA(1'b1)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_ctrl_o(out_ctrl_o), .out_data_o(out_data_o),
      .sb_i(sb_i), .sb_o(sb_o)
   );

   always #5 clk_i = ~clk_i;

   logic [47:0] scb[$];
   int checks   = 0;
   int errors   = 0;
   int accepted = 0;
   int emitted  = 0;
   int stalls   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive, check pre-edge state against the queue model, update the model, cross the edge.
   task automatic step(input logic v, input logic [15:0] c, input logic [31:0] d,
                       input logic rdy, input logic fl, input logic [1:0] sb);
      logic        in_acc;
      logic        out_acc;
      logic        exp_rdy;
      logic [47:0] beat;
      in_valid_i  = v;
      in_ctrl_i   = c;
      in_data_i   = d;
      out_ready_i = rdy;
      flush_i     = fl;
      sb_i        = sb;
      #1;
      exp_rdy = SKID ? (scb.size() < 2) : ((scb.size() == 0) || rdy);
      check("out_valid", 64'(out_valid_o), 64'(scb.size() != 0));
      check("in_ready", 64'(in_ready_o), 64'(exp_rdy));
      if (!out_valid_o) check("bubble_ctrl", 64'(out_ctrl_o), 64'd0);
      in_acc  = v && in_ready_o;
      out_acc = out_valid_o && rdy;
      if (v && !in_ready_o) stalls++;
      if (out_acc) begin
         check("pop_nonempty", 64'(scb.size() != 0), 64'd1);
         if (scb.size() != 0) begin
            beat = scb.pop_front();
            check("beat_ctrl", 64'(out_ctrl_o), 64'(beat[47:32]));
            check("beat_data", 64'(out_data_o), 64'(beat[31:0]));
            emitted++;
         end
      end
      if (fl) scb.delete();
      else if (in_acc) begin
         scb.push_back({c, d});
         accepted++;
      end
      @(posedge clk_i);
      #1;
      check("sb_follow", 64'(sb_o), 64'(sb));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
      in_ctrl_i = '0; in_data_i = '0; sb_i = 2'b11;
      #2;
      check("rst_valid", 64'(out_valid_o), 64'd0);
      check("rst_ctrl", 64'(out_ctrl_o), 64'd0);
      check("rst_data", 64'(out_data_o), 64'd0);
      check("rst_sb", 64'(sb_o), 64'(SB_RST));
      @(posedge clk_i); #1;
      check("rst_sb_hold", 64'(sb_o), 64'(SB_RST));
      @(negedge clk_i) rst_i = 1'b1;
      @(posedge clk_i); #1;
      check("rst_in_ready", 64'(in_ready_o), 64'd1);
      check("sb_after_rst", 64'(sb_o), 64'(2'b11));

      // Basic one-cycle latency.
      step(1'b1, 16'h00A5, 32'h1234, 1'b1, 1'b0, 2'b00);
      check("lat_valid", 64'(out_valid_o), 64'd1);
      check("lat_ctrl", 64'(out_ctrl_o), 64'h00A5);
      check("lat_data", 64'(out_data_o), 64'h1234);
      step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 2'b00);

      // Stall for three cycles holding DEAD; BEEF is offered throughout.
      step(1'b1, 16'h0011, 32'hDEAD, 1'b1, 1'b0, 2'b01);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 16'h0022, 32'hBEEF, 1'b0, 1'b0, (i == 2) ? 2'b10 : 2'b01);
         check("stall_valid", 64'(out_valid_o), 64'd1);
         check("stall_ctrl", 64'(out_ctrl_o), 64'h0011);
         check("stall_data", 64'(out_data_o), 64'hDEAD);
      end
      check("stall_sb", 64'(sb_o), 64'(2'b10));
      step(1'b1, 16'h0022, 32'hBEEF, 1'b1, 1'b0, 2'b00);
      check("release_data", 64'(out_data_o), 64'hBEEF);
      step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 2'b00);
      step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 2'b00);

      // Flush with main (and skid, if present) full while 0F0F is offered.
      step(1'b1, 16'h0033, 32'hA1A1, 1'b0, 1'b0, 2'b01);
      step(1'b1, 16'h0044, 32'hB2B2, 1'b0, 1'b0, 2'b01);
      step(1'b1, 16'h0055, 32'h0F0F, 1'b0, 1'b1, 2'b10);
      check("flush_valid", 64'(out_valid_o), 64'd0);
      check("flush_ctrl", 64'(out_ctrl_o), 64'd0);
      check("flush_data", 64'(out_data_o), 64'd0);
      check("flush_sb", 64'(sb_o), 64'(2'b10));
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 2'b00);

      // Flush on an empty stage swallows the accepted beat.
      step(1'b1, 16'h0066, 32'h0F0F, 1'b1, 1'b1, 2'b01);
      check("flush_load_valid", 64'(out_valid_o), 64'd0);
      step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 2'b00);

      // Asynchronous reset mid-stall.
      step(1'b1, 16'h0077, 32'hC0DE, 1'b0, 1'b0, 2'b10);
      step(1'b1, 16'h0088, 32'hFACE, 1'b0, 1'b0, 2'b10);
      #2;
      rst_i = 1'b0;
      in_valid_i = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid_o), 64'd0);
      check("arst_ctrl", 64'(out_ctrl_o), 64'd0);
      check("arst_data", 64'(out_data_o), 64'd0);
      check("arst_sb", 64'(sb_o), 64'(SB_RST));
      scb.delete();
      #3;
      rst_i = 1'b1;
      #1;
      check("arst_in_ready", 64'(in_ready_o), 64'd1);
      @(posedge clk_i); #1;
      step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 2'b00);

      // 100 random beats with random handshakes.
      accepted = 0;
      emitted  = 0;
      for (int n = 0; n < 3000 && accepted < 100; n++)
         step(1'($urandom_range(0, 1)), 16'($urandom), $urandom,
              1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)));
      for (int n = 0; n < 10 && scb.size() != 0; n++)
         step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 2'b00);
      check("rand_accepted", 64'(accepted), 64'd100);
      check("rand_emitted", 64'(emitted), 64'd100);
      check("rand_drained", 64'(scb.size()), 64'd0);

      // Continuous flow with downstream always ready: no input stalls.
      stalls   = 0;
      accepted = 0;
      for (int n = 0; n < 20; n++)
         step(1'b1, 16'(n + 1), 32'(n * 3 + 7), 1'b1, 1'b0, 2'b01);
      step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 2'b00);
      check("flow_stalls", 64'(stalls), 64'd0);
      check("flow_accepted", 64'(accepted), 64'd20);
      check("flow_drained", 64'(scb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
